// File: rtl/adc_row_readout.sv
// Serial-ADC row readout: each enabled row_select rising edge runs SAMPLES_PER_ROW conversions into a FWFT FIFO.
// Latency: a word lands in the FIFO CONV_CYCLES + 2*SCLK_DIV*ADC_BITS + 1 cycles after its conversion starts.
// Backpressure: none toward the ADC; a result is dropped and the sticky overflow flag is set when the FIFO is full at push time.
module adc_row_readout #(
    parameter int ADC_BITS        = 12,
    parameter int SAMPLES_PER_ROW = 4,
    parameter int SCLK_DIV        = 2,
    parameter int CONV_CYCLES     = 20,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          row_select,
    input  logic                          enable,
    output logic                          adc_cs_n,
    output logic                          adc_sclk,
    input  logic                          adc_sdo,
    input  logic                          rd_en,
    output logic [15:0]                   rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = 16;
    localparam int HW = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CONV  = 3'd1,
        SHIFT = 3'd2,
        PUSH  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t                state_q;
    logic                  row_prev_q;
    logic                  start;
    logic [CW-1:0]         cnt_q;
    logic [HW-1:0]         half_q;
    logic [3:0]            idx_q;
    logic [ADC_BITS-1:0]   sreg_q;
    logic                  cs_n_q;
    logic                  sclk_q;
    logic                  busy_q;

    logic [15:0]           mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [AW:0]           count_q;
    logic                  ovf_q;
    logic                  push_req;
    logic                  pop;
    logic                  full_w;
    logic                  do_push;
    logic [15:0]           wr_word;

    // Rising-edge detect on row_select; edges seen while disabled never start a burst.
    always_ff @(posedge clk) begin
        if (reset) row_prev_q <= 1'b0;
        else       row_prev_q <= row_select;
    end

    assign start = row_select & ~row_prev_q & enable;

    // Conversion sequencer: cs/sclk/busy are registered alongside the state so outputs are glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            half_q  <= '0;
            idx_q   <= '0;
            sreg_q  <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    if (cnt_q == CW'(CONV_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        half_q  <= '0;
                        sclk_q  <= 1'b0;
                        state_q <= SHIFT;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                SHIFT: begin
                    if (cnt_q == CW'(SCLK_DIV - 1)) begin
                        cnt_q <= '0;
                        // The last half-period is the high phase after the final rising edge, so sclk exits high.
                        if (half_q == HW'(2 * ADC_BITS - 1)) begin
                            cs_n_q  <= 1'b1;
                            state_q <= PUSH;
                        end else begin
                            half_q <= half_q + HW'(1);
                            sclk_q <= ~sclk_q;
                            if (!sclk_q) sreg_q <= {sreg_q[ADC_BITS-2:0], adc_sdo};
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                PUSH: begin
                    if (idx_q == 4'(SAMPLES_PER_ROW - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        idx_q   <= idx_q + 4'd1;
                        cnt_q   <= '0;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    if (cnt_q == CW'(1)) begin
                        cnt_q   <= '0;
                        cs_n_q  <= 1'b0;
                        state_q <= CONV;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cs_n_q  <= 1'b1;
                    sclk_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign push_req = (state_q == PUSH);
    assign pop      = rd_en && (count_q != '0);
    assign full_w   = (count_q == (AW+1)'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the word.
    assign do_push  = push_req && (!full_w || pop);
    assign wr_word  = {idx_q, 12'(sreg_q)};

    // FIFO storage; contents need no reset because rd_data is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_word;
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            if (push_req && full_w && !pop) ovf_q <= 1'b1;
        end
    end

    assign adc_cs_n = cs_n_q;
    assign adc_sclk = sclk_q;
    assign busy     = busy_q;
    assign empty    = (count_q == '0);
    assign full     = full_w;
    assign count    = count_q;
    assign overflow = ovf_q;
    assign rd_data  = empty ? 16'h0000 : mem_q[rd_ptr_q];

endmodule
